// File: rtl/sort8_ctrl_if.sv
// Handshake bundle for sort8_ctrl: byte input stream, sorted byte output stream, busy flag.
interface sort8_ctrl_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sort8_ctrl.sv
// Eight-byte frame sorter: load 8 bytes, sort with one time-shared 4-input network
// over five passes, then stream them out in ascending unsigned order.
module sort4 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a0,
    input  logic [W-1:0] i_a1,
    input  logic [W-1:0] i_a2,
    input  logic [W-1:0] i_a3,
    output logic [W-1:0] o_0,
    output logic [W-1:0] o_1,
    output logic [W-1:0] o_2,
    output logic [W-1:0] o_3
);
    logic [W-1:0] w_l01, w_h01, w_l23, w_h23, w_m1, w_m2;

    assign w_l01 = (i_a0 < i_a1) ? i_a0 : i_a1;
    assign w_h01 = (i_a0 < i_a1) ? i_a1 : i_a0;
    assign w_l23 = (i_a2 < i_a3) ? i_a2 : i_a3;
    assign w_h23 = (i_a2 < i_a3) ? i_a3 : i_a2;
    assign o_0   = (w_l01 < w_l23) ? w_l01 : w_l23;
    assign w_m1  = (w_l01 < w_l23) ? w_l23 : w_l01;
    assign w_m2  = (w_h01 < w_h23) ? w_h01 : w_h23;
    assign o_3   = (w_h01 < w_h23) ? w_h23 : w_h01;
    assign o_1   = (w_m1 < w_m2) ? w_m1 : w_m2;
    assign o_2   = (w_m1 < w_m2) ? w_m2 : w_m1;
endmodule

module sort8_ctrl #(
    parameter int W = 8
) (
    input logic         clk,
    input logic         rst,
    sort8_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_UNLOAD
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [W-1:0] r_mem [8];
    logic [2:0]   r_idx;
    logic [2:0]   r_pc;

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_in_fire;
    logic         w_out_fire;
    logic [2:0]   w_sel0, w_sel1, w_sel2, w_sel3;
    logic [W-1:0] w_s0, w_s1, w_s2, w_s3;

    // Pass schedule: sort both halves, merge the low pairs, merge the high pairs,
    // then the middle four hold the remaining ranks and need one final sort.
    always_comb begin
        w_sel0 = 3'd2;
        w_sel1 = 3'd3;
        w_sel2 = 3'd4;
        w_sel3 = 3'd5;
        case (r_pc)
            3'd0: begin w_sel0 = 3'd0; w_sel1 = 3'd1; w_sel2 = 3'd2; w_sel3 = 3'd3; end
            3'd1: begin w_sel0 = 3'd4; w_sel1 = 3'd5; w_sel2 = 3'd6; w_sel3 = 3'd7; end
            3'd2: begin w_sel0 = 3'd0; w_sel1 = 3'd1; w_sel2 = 3'd4; w_sel3 = 3'd5; end
            3'd3: begin w_sel0 = 3'd2; w_sel1 = 3'd3; w_sel2 = 3'd6; w_sel3 = 3'd7; end
            default: ;
        endcase
    end

    sort4 #(.W(W)) u_sort4 (
        .i_a0(r_mem[w_sel0]),
        .i_a1(r_mem[w_sel1]),
        .i_a2(r_mem[w_sel2]),
        .i_a3(r_mem[w_sel3]),
        .o_0 (w_s0),
        .o_1 (w_s1),
        .o_2 (w_s2),
        .o_3 (w_s3)
    );

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_idx == 3'd7) w_next_state = S_SORT;
            end
            S_SORT: begin
                if (r_pc == 3'd4) w_next_state = S_UNLOAD;
            end
            S_UNLOAD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && r_idx == 3'd7) w_next_state = S_LOAD;
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_pc    <= '0;
            for (int unsigned k = 0; k < 8; k++) r_mem[k] <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_mem[r_idx] <= bus.in_data;
                        r_idx        <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_pc <= '0;
                    end
                end
                S_SORT: begin
                    r_mem[w_sel0] <= w_s0;
                    r_mem[w_sel1] <= w_s1;
                    r_mem[w_sel2] <= w_s2;
                    r_mem[w_sel3] <= w_s3;
                    if (r_pc == 3'd4) begin
                        r_pc  <= '0;
                        r_idx <= '0;
                    end else begin
                        r_pc <= r_pc + 3'd1;
                    end
                end
                S_UNLOAD: begin
                    if (w_out_fire) r_idx <= r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_mem[r_idx];
    assign bus.busy      = (r_state != S_LOAD);
endmodule

// File: tb/tb_sort8_ctrl.sv
// Self-checking bench for sort8_ctrl: directed frame table, multi-cycle corner
// sequences, and random frames checked against a counting-sort reference.
module tb_sort8_ctrl;
    typedef logic [7:0] frame_t [8];
    typedef struct {
        frame_t din;
        frame_t dexp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sort8_ctrl_if #(.W(8)) bus ();
    sort8_ctrl #(.W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: emit values in ascending order by scanning all byte values.
    task automatic sort_ref(input frame_t d, output frame_t s);
        int k = 0;
        for (int v = 0; v < 256; v++)
            for (int i = 0; i < 8; i++)
                if (int'(d[i]) == v) begin
                    s[k] = d[i];
                    k++;
                end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, int'(bus.in_ready), 1);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic load_frame(input frame_t d, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'h5A;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d[i];
            for (int c = 0; c < 50 && !bus.in_ready; c++) step();
            if (!bus.in_ready) check("load_timeout", 0, 1);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // Called right after the 8th accept edge; junk on in_valid must be ignored.
    task automatic wait_sort();
        int cnt = 0;
        check("sort_busy", int'(bus.busy), 1);
        check("sort_in_ready", int'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        while (!bus.out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        check("latency", cnt, 5);
    endtask

    task automatic unload_frame(input frame_t exp, input bit rand_stall, input int stall_first);
        int k = 0;
        int cyc = 0;
        int sf = stall_first;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        while (k < 8 && cyc < 300) begin
            if (sf > 0) begin
                bus.out_ready = 1'b0;
                sf--;
            end else if (rand_stall) bus.out_ready = 1'($urandom_range(0, 1));
            else bus.out_ready = 1'b1;
            check("out_valid", int'(bus.out_valid), 1);
            check($sformatf("out_data[%0d]", k), int'(bus.out_data), int'(exp[k]));
            if (bus.out_valid && bus.out_ready) k++;
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("unload_done", k, 8);
        check_idle("post_unload");
    endtask

    vec_t vecs [5];
    frame_t fin, fexp;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;

        vecs[0].din  = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        vecs[0].dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9};
        vecs[1].din  = '{8'hFF, 8'h00, 8'h80, 8'h80, 8'h01, 8'hFE, 8'h00, 8'h7F};
        vecs[1].dexp = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFE, 8'hFF};
        vecs[2].din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vecs[2].dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        vecs[3].din  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        vecs[3].dexp = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
        vecs[4].din  = '{8'd200, 8'd3, 8'd200, 8'd0, 8'd99, 8'd3, 8'd255, 8'd1};
        vecs[4].dexp = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd99, 8'd200, 8'd200, 8'd255};

        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_out_data", int'(bus.out_data), 0);

        // Back-to-back frames with no idle cycle between them.
        foreach (vecs[v]) begin
            load_frame(vecs[v].din, 1'b0);
            wait_sort();
            unload_frame(vecs[v].dexp, 1'b0, 0);
        end

        // Gapped input, then out_ready held low for four cycles at the minimum.
        for (int i = 0; i < 8; i++) fin[i] = 8'($urandom_range(0, 255));
        sort_ref(fin, fexp);
        load_frame(fin, 1'b1);
        wait_sort();
        unload_frame(fexp, 1'b0, 4);

        // Reset during pass2 discards the frame.
        load_frame(vecs[0].din, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("rst_sort");
        check("rst_sort_out_data", int'(bus.out_data), 0);
        for (int i = 0; i < 8; i++) fin[i] = 8'd5;
        load_frame(fin, 1'b0);
        wait_sort();
        unload_frame(fin, 1'b0, 0);

        // Reset after three output beats.
        load_frame(vecs[2].din, 1'b0);
        wait_sort();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("pre_rst_data", int'(bus.out_data), int'(vecs[2].dexp[i]));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_unload");
        check("rst_unload_out_data", int'(bus.out_data), 0);

        // Random frames, narrow value ranges to force duplicates.
        for (int f = 0; f < 20; f++) begin
            int hi;
            hi = (f % 3 == 0) ? 3 : 255;
            for (int i = 0; i < 8; i++) fin[i] = 8'($urandom_range(0, hi));
            sort_ref(fin, fexp);
            load_frame(fin, 1'($urandom_range(0, 1)));
            wait_sort();
            unload_frame(fexp, 1'b1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
